// File: rtl/jelly_axi4_pkg.sv
// Shared definitions for the jelly AXI4 slave RAM.
// Holds the AXI burst and response encodings and the state types
// for the write and read channel FSMs.
package jelly_axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/jelly_lfsr16_throttle.sv
// Pseudo-random ready throttle.
// A 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every cycle.
// Ports:
//   clk   - clock
//   reset - asynchronous active-high reset, reloads LFSR_SEED
//   gate  - LFSR bit 0 when STALL_ENABLE is set, otherwise constant 1
module jelly_lfsr16_throttle #(
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          STALL_ENABLE = 0
)(
    input  logic clk,
    input  logic reset,
    output logic gate
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    always_comb begin
        gate = (STALL_ENABLE != 0) ? lfsr_q[0] : 1'b1;
    end

endmodule

// File: rtl/jelly_axi4_slave_ram.sv
// AXI4 slave memory backed by an internal word array.
// Write channel: AW -> W beats -> B.  Read channel: AR -> latency wait -> R beats.
// Both channels run independently; a same-cycle write and read-load of one
// word returns the old contents to the reader.
// Ports:
//   clk, reset        - clock and asynchronous active-high reset
//   s_axi4_aw*/w*/b*  - AXI4 write address, data and response channels
//   s_axi4_ar*/r*     - AXI4 read address and data channels
module jelly_axi4_slave_ram
    import jelly_axi4_pkg::*;
#(
    parameter int          ID_WIDTH     = 6,
    parameter int          ADDR_WIDTH   = 32,
    parameter int          DATA_SIZE    = 3,
    parameter int          MEM_WIDTH    = 16,
    parameter int          READ_LATENCY = 4,
    parameter int          STALL_ENABLE = 0,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    localparam int         DATA_WIDTH   = 8 << DATA_SIZE,
    localparam int         STRB_WIDTH   = DATA_WIDTH / 8
)(
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ID_WIDTH-1:0]   s_axi4_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi4_awaddr,
    input  logic [7:0]            s_axi4_awlen,
    input  logic [2:0]            s_axi4_awsize,
    input  logic [1:0]            s_axi4_awburst,
    input  logic                  s_axi4_awvalid,
    output logic                  s_axi4_awready,

    input  logic [DATA_WIDTH-1:0] s_axi4_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi4_wstrb,
    input  logic                  s_axi4_wlast,
    input  logic                  s_axi4_wvalid,
    output logic                  s_axi4_wready,

    output logic [ID_WIDTH-1:0]   s_axi4_bid,
    output logic [1:0]            s_axi4_bresp,
    output logic                  s_axi4_bvalid,
    input  logic                  s_axi4_bready,

    input  logic [ID_WIDTH-1:0]   s_axi4_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi4_araddr,
    input  logic [7:0]            s_axi4_arlen,
    input  logic [2:0]            s_axi4_arsize,
    input  logic [1:0]            s_axi4_arburst,
    input  logic                  s_axi4_arvalid,
    output logic                  s_axi4_arready,

    output logic [ID_WIDTH-1:0]   s_axi4_rid,
    output logic [DATA_WIDTH-1:0] s_axi4_rdata,
    output logic [1:0]            s_axi4_rresp,
    output logic                  s_axi4_rlast,
    output logic                  s_axi4_rvalid,
    input  logic                  s_axi4_rready
);

    localparam logic [7:0] LAT_INIT = 8'(READ_LATENCY - 1);

    // FIXED holds the address; INCR and WRAP both step by the beat size.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        return (burst == BURST_FIXED) ? addr : addr + (ADDR_WIDTH'(1) << size);
    endfunction

    logic gate;

    jelly_lfsr16_throttle #(
        .LFSR_SEED    (LFSR_SEED),
        .STALL_ENABLE (STALL_ENABLE)
    ) u_throttle (
        .clk   (clk),
        .reset (reset),
        .gate  (gate)
    );

    logic [DATA_WIDTH-1:0] mem_q [0:(1 << MEM_WIDTH) - 1];

    // ---------------- write channel ----------------
    wr_state_t             w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   w_id_q,    w_id_d;
    logic [ADDR_WIDTH-1:0] w_addr_q,  w_addr_d;
    logic [7:0]            w_len_q,   w_len_d;
    logic [2:0]            w_size_q,  w_size_d;
    logic [1:0]            w_burst_q, w_burst_d;
    logic [7:0]            w_beat_q,  w_beat_d;
    logic                  w_err_q,   w_err_d;
    logic                  mem_we;
    logic [MEM_WIDTH-1:0]  w_idx;

    always_comb begin
        w_state_d      = w_state_q;
        w_id_d         = w_id_q;
        w_addr_d       = w_addr_q;
        w_len_d        = w_len_q;
        w_size_d       = w_size_q;
        w_burst_d      = w_burst_q;
        w_beat_d       = w_beat_q;
        w_err_d        = w_err_q;
        mem_we         = 1'b0;
        s_axi4_awready = 1'b0;
        s_axi4_wready  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                s_axi4_awready = gate & ~reset;
                if (s_axi4_awvalid && s_axi4_awready) begin
                    w_id_d    = s_axi4_awid;
                    w_addr_d  = s_axi4_awaddr;
                    w_len_d   = s_axi4_awlen;
                    w_size_d  = s_axi4_awsize;
                    w_burst_d = s_axi4_awburst;
                    w_beat_d  = '0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                s_axi4_wready = gate & ~reset;
                if (s_axi4_wvalid && s_axi4_wready) begin
                    mem_we   = 1'b1;
                    w_addr_d = next_addr(w_addr_q, w_size_q, w_burst_q);
                    w_beat_d = w_beat_q + 8'd1;
                    // A misplaced wlast flags the burst but never shortens it.
                    if (s_axi4_wlast != (w_beat_q == w_len_q)) begin
                        w_err_d = 1'b1;
                    end
                    if (w_beat_q == w_len_q) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (s_axi4_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_beat_q  <= '0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_beat_q  <= w_beat_d;
            w_err_q   <= w_err_d;
        end
    end

    always_comb begin
        w_idx         = w_addr_q[DATA_SIZE +: MEM_WIDTH];
        s_axi4_bvalid = (w_state_q == W_RESP);
        s_axi4_bid    = w_id_q;
        s_axi4_bresp  = (s_axi4_bvalid && w_err_q) ? RESP_SLVERR : RESP_OKAY;
    end

    // Memory is deliberately outside the reset domain: contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
                if (s_axi4_wstrb[i]) begin
                    mem_q[w_idx][i*8 +: 8] <= s_axi4_wdata[i*8 +: 8];
                end
            end
        end
    end

    // ---------------- read channel ----------------
    rd_state_t             r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   r_id_q,    r_id_d;
    logic [ADDR_WIDTH-1:0] r_addr_q,  r_addr_d;
    logic [7:0]            r_len_q,   r_len_d;
    logic [2:0]            r_size_q,  r_size_d;
    logic [1:0]            r_burst_q, r_burst_d;
    logic [7:0]            r_beat_q,  r_beat_d;
    logic [7:0]            r_cnt_q,   r_cnt_d;
    logic [DATA_WIDTH-1:0] r_data_q,  r_data_d;
    logic                  r_last_q,  r_last_d;
    logic                  r_load;
    logic [ADDR_WIDTH-1:0] r_load_addr;

    // The data register is loaded one cycle before rvalid, so the load happens
    // when the counter reads 1 (or directly at the AR handshake for latency 1).
    always_comb begin
        r_state_d      = r_state_q;
        r_id_d         = r_id_q;
        r_addr_d       = r_addr_q;
        r_len_d        = r_len_q;
        r_size_d       = r_size_q;
        r_burst_d      = r_burst_q;
        r_beat_d       = r_beat_q;
        r_cnt_d        = r_cnt_q;
        r_last_d       = r_last_q;
        r_load         = 1'b0;
        r_load_addr    = r_addr_q;
        s_axi4_arready = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                s_axi4_arready = gate & ~reset;
                if (s_axi4_arvalid && s_axi4_arready) begin
                    r_id_d    = s_axi4_arid;
                    r_addr_d  = s_axi4_araddr;
                    r_len_d   = s_axi4_arlen;
                    r_size_d  = s_axi4_arsize;
                    r_burst_d = s_axi4_arburst;
                    r_beat_d  = '0;
                    r_cnt_d   = LAT_INIT;
                    if (LAT_INIT == 8'd0) begin
                        r_load      = 1'b1;
                        r_load_addr = s_axi4_araddr;
                        r_last_d    = (s_axi4_arlen == 8'd0);
                        r_state_d   = R_DATA;
                    end else begin
                        r_state_d   = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_cnt_q <= 8'd1) begin
                    r_cnt_d   = '0;
                    r_load    = 1'b1;
                    r_last_d  = (r_len_q == 8'd0);
                    r_state_d = R_DATA;
                end else begin
                    r_cnt_d   = r_cnt_q - 8'd1;
                end
            end
            R_DATA: begin
                if (s_axi4_rready) begin
                    if (r_last_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_addr_d    = next_addr(r_addr_q, r_size_q, r_burst_q);
                        r_beat_d    = r_beat_q + 8'd1;
                        r_load      = 1'b1;
                        r_load_addr = r_addr_d;
                        r_last_d    = ((r_beat_q + 8'd1) == r_len_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        r_data_d = r_load ? mem_q[r_load_addr[DATA_SIZE +: MEM_WIDTH]] : r_data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_beat_q  <= '0;
            r_cnt_q   <= '0;
            r_data_q  <= '0;
            r_last_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_beat_q  <= r_beat_d;
            r_cnt_q   <= r_cnt_d;
            r_data_q  <= r_data_d;
            r_last_q  <= r_last_d;
        end
    end

    always_comb begin
        s_axi4_rvalid = (r_state_q == R_DATA);
        s_axi4_rid    = r_id_q;
        s_axi4_rdata  = r_data_q;
        s_axi4_rlast  = r_last_q & s_axi4_rvalid;
        s_axi4_rresp  = RESP_OKAY;
    end

endmodule

// File: tb/tb_jelly_axi4_slave_ram.sv
// Self-checking bench for jelly_axi4_slave_ram with ready throttling enabled.
module tb_jelly_axi4_slave_ram;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = 3'd3;
    logic [1:0]  awburst = 2'b01;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [5:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [5:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = 3'd3;
    logic [1:0]  arburst = 2'b01;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [5:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;

    jelly_axi4_slave_ram #(
        .ID_WIDTH     (6),
        .ADDR_WIDTH   (32),
        .DATA_SIZE    (3),
        .MEM_WIDTH    (16),
        .READ_LATENCY (LAT),
        .STALL_ENABLE (1),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .s_axi4_awid    (awid),
        .s_axi4_awaddr  (awaddr),
        .s_axi4_awlen   (awlen),
        .s_axi4_awsize  (awsize),
        .s_axi4_awburst (awburst),
        .s_axi4_awvalid (awvalid),
        .s_axi4_awready (awready),
        .s_axi4_wdata   (wdata),
        .s_axi4_wstrb   (wstrb),
        .s_axi4_wlast   (wlast),
        .s_axi4_wvalid  (wvalid),
        .s_axi4_wready  (wready),
        .s_axi4_bid     (bid),
        .s_axi4_bresp   (bresp),
        .s_axi4_bvalid  (bvalid),
        .s_axi4_bready  (bready),
        .s_axi4_arid    (arid),
        .s_axi4_araddr  (araddr),
        .s_axi4_arlen   (arlen),
        .s_axi4_arsize  (arsize),
        .s_axi4_arburst (arburst),
        .s_axi4_arvalid (arvalid),
        .s_axi4_arready (arready),
        .s_axi4_rid     (rid),
        .s_axi4_rdata   (rdata),
        .s_axi4_rresp   (rresp),
        .s_axi4_rlast   (rlast),
        .s_axi4_rvalid  (rvalid),
        .s_axi4_rready  (rready)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic summary();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    endtask

    task automatic timeout(input string name);
        total++;
        $display("FAIL %s: timed out waiting for handshake", name);
        summary();
    endtask

    // ---------------- reference model ----------------
    logic [63:0] ref_mem [int unsigned];

    function automatic int unsigned widx(input logic [31:0] a);
        return (a >> 3) & 32'h0000_FFFF;
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int beat,
                                              input logic [2:0] size, input logic [1:0] burst);
        return (burst == 2'b00) ? a : a + 32'(beat) * (32'd1 << size);
    endfunction

    typedef struct { logic [5:0] id; logic [63:0] data; logic last; } rexp_t;
    typedef struct { logic [5:0] id; logic [1:0] resp; } bexp_t;
    rexp_t rq[$];
    bexp_t bq[$];

    logic [63:0] wbuf [256];
    logic [7:0]  sbuf [256];

    // ---------------- output compare ----------------
    int unsigned ar_hs_cyc = 0, first_beat_cyc = 0, last_beat_cyc = 0;
    bit          await_first = 0;
    bit          prev_rstall = 0, prev_bstall = 0;
    logic [63:0] prev_rdata;
    logic [5:0]  prev_bid;
    logic [63:0] last_rdata = '0;
    logic [1:0]  last_bresp = '0;

    initial forever begin
        @(negedge clk);
        if (reset) begin
            prev_rstall = 0;
            prev_bstall = 0;
            await_first = 0;
        end else begin
            if (arvalid && arready) begin
                ar_hs_cyc   = cyc;
                await_first = 1;
            end
            if (prev_rstall) begin
                check("r_valid_held", {63'd0, rvalid}, 64'd1);
                check("r_data_stable", rdata, prev_rdata);
            end
            if (rvalid) begin
                if (await_first) begin
                    check("r_latency", 64'(cyc - ar_hs_cyc), 64'(LAT));
                    await_first    = 0;
                    first_beat_cyc = cyc;
                end
                if (rq.size() == 0) begin
                    check("r_unexpected_beat", {63'd0, rvalid}, 64'd0);
                end else begin
                    check("rid", {58'd0, rid}, {58'd0, rq[0].id});
                    check("rdata", rdata, rq[0].data);
                    check("rlast", {63'd0, rlast}, {63'd0, rq[0].last});
                    check("rresp", {62'd0, rresp}, 64'd0);
                    if (rready) begin
                        last_rdata    = rdata;
                        last_beat_cyc = cyc;
                        void'(rq.pop_front());
                    end
                end
            end
            prev_rstall = rvalid && !rready;
            prev_rdata  = rdata;

            if (prev_bstall) begin
                check("b_valid_held", {63'd0, bvalid}, 64'd1);
                check("b_id_stable", {58'd0, bid}, {58'd0, prev_bid});
            end
            if (bvalid) begin
                if (bq.size() == 0) begin
                    check("b_unexpected", {63'd0, bvalid}, 64'd0);
                end else begin
                    check("bid", {58'd0, bid}, {58'd0, bq[0].id});
                    check("bresp", {62'd0, bresp}, {62'd0, bq[0].resp});
                    if (bready) begin
                        last_bresp = bresp;
                        void'(bq.pop_front());
                    end
                end
            end
            prev_bstall = bvalid && !bready;
            prev_bid    = bid;
        end
    end

    // ---------------- ready drivers ----------------
    int rmode = 0;  // 0: rready high, 1: toggle every cycle
    initial forever begin
        @(posedge clk);
        #1;
        rready = (rmode == 0) ? 1'b1 : ~rready;
        bready = 1'($urandom_range(0, 1));
    end

    // ---------------- stimulus tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_burst(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int bad_last);
        bit err = 0;
        for (int b = 0; b <= int'(len); b++) begin
            int unsigned k = widx(beat_addr(addr, b, size, burst));
            logic [63:0] w = ref_mem.exists(k) ? ref_mem[k] : 64'd0;
            bit wl = (bad_last >= 0) ? (b == bad_last) : (b == int'(len));
            for (int i = 0; i < 8; i++) if (sbuf[b][i]) w[i*8 +: 8] = wbuf[b][i*8 +: 8];
            ref_mem[k] = w;
            if (wl != (b == int'(len))) err = 1;
        end
        bq.push_back('{id, err ? 2'b10 : 2'b00});
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (awready) break;
            if (t > 200) timeout("aw_handshake");
        end
        tick();
        awvalid = 0;
        for (int b = 0; b <= int'(len); b++) begin
            wdata  = wbuf[b];
            wstrb  = sbuf[b];
            wlast  = (bad_last >= 0) ? (b == bad_last) : (b == int'(len));
            wvalid = 1;
            for (int t = 0; ; t++) begin
                @(negedge clk);
                if (wready) break;
                if (t > 200) timeout("w_handshake");
            end
            tick();
        end
        wvalid = 0;
        wlast  = 0;
        for (int t = 0; bq.size() != 0; t++) begin
            @(negedge clk);
            if (t > 200) timeout("b_handshake");
        end
        tick();
    endtask

    task automatic ar_issue(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        for (int b = 0; b <= int'(len); b++)
            rq.push_back('{id, ref_mem[widx(beat_addr(addr, b, size, burst))], b == int'(len)});
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (arready) break;
            if (t > 200) timeout("ar_handshake");
        end
        tick();
        arvalid = 0;
    endtask

    task automatic rd_burst(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        ar_issue(id, addr, len, size, burst);
        for (int t = 0; rq.size() != 0; t++) begin
            @(negedge clk);
            if (t > 2000) timeout("r_drain");
        end
        tick();
    endtask

    initial begin
        #500000;
        timeout("watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_awready", {63'd0, awready}, 64'd0);
        check("rst_wready", {63'd0, wready}, 64'd0);
        check("rst_arready", {63'd0, arready}, 64'd0);
        check("rst_bvalid", {63'd0, bvalid}, 64'd0);
        check("rst_rvalid", {63'd0, rvalid}, 64'd0);
        check("rst_ids", {52'd0, bid, rid}, 64'd0);
        check("rst_rdata", rdata, 64'd0);
        check("rst_resp", {60'd0, bresp, rresp}, 64'd0);
        tick();
        reset = 0;

        // Four-beat INCR write and readback with rready held high.
        wbuf[0] = 64'h1111_1111_1111_1111; wbuf[1] = 64'h2222_2222_2222_2222;
        wbuf[2] = 64'h3333_3333_3333_3333; wbuf[3] = 64'h4444_4444_4444_4444;
        for (int i = 0; i < 4; i++) sbuf[i] = 8'hFF;
        wr_burst(6'h15, 32'h100, 8'd3, 3'd3, 2'b01, -1);
        check("b_resp_okay", {62'd0, last_bresp}, 64'd0);
        check("model_word_0x110", ref_mem[32'h22], 64'h3333_3333_3333_3333);
        rd_burst(6'h2A, 32'h100, 8'd3, 3'd3, 2'b01);
        check("incr_last_data", last_rdata, 64'h4444_4444_4444_4444);
        check("r_back_to_back", 64'(last_beat_cyc - first_beat_cyc), 64'd3);

        // Word index aliasing above 2^16 words.
        rd_burst(6'h01, 32'h0008_0100, 8'd0, 3'd3, 2'b01);
        check("alias_data", last_rdata, 64'h1111_1111_1111_1111);

        // Byte-strobe narrow write over an all-ones word.
        wbuf[0] = '1; sbuf[0] = 8'hFF;
        wr_burst(6'h02, 32'h200, 8'd0, 3'd3, 2'b01, -1);
        wbuf[0] = 64'h0000_0000_AB00_0000; sbuf[0] = 8'h08;
        wr_burst(6'h03, 32'h203, 8'd0, 3'd0, 2'b01, -1);
        check("model_strobe", ref_mem[32'h40], 64'hFFFF_FFFF_ABFF_FFFF);
        rd_burst(6'h04, 32'h200, 8'd0, 3'd3, 2'b01);
        check("strobe_data", last_rdata, 64'hFFFF_FFFF_ABFF_FFFF);

        // FIXED burst: last beat wins.
        wbuf[0] = 64'd1; wbuf[1] = 64'd2; wbuf[2] = 64'd3;
        for (int i = 0; i < 3; i++) sbuf[i] = 8'hFF;
        wr_burst(6'h05, 32'h40, 8'd2, 3'd3, 2'b00, -1);
        rd_burst(6'h06, 32'h40, 8'd0, 3'd3, 2'b01);
        check("fixed_data", last_rdata, 64'd3);

        // Early wlast: SLVERR, yet all four beats land.
        for (int i = 0; i < 4; i++) begin wbuf[i] = 64'hA0 + 64'(i); sbuf[i] = 8'hFF; end
        wr_burst(6'h07, 32'h300, 8'd3, 3'd3, 2'b01, 1);
        check("wlast_err_bresp", {62'd0, last_bresp}, 64'd2);
        rd_burst(6'h08, 32'h300, 8'd3, 3'd3, 2'b01);
        check("wlast_err_data", last_rdata, 64'hA3);

        // Fill a scratch region, then random bursts with toggling rready.
        for (int i = 0; i < 256; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
        wr_burst(6'h09, 32'h1000, 8'd255, 3'd3, 2'b01, -1);
        rmode = 1;
        for (int n = 0; n < 16; n++) begin
            logic [31:0] a = 32'h1000 + 32'($urandom_range(0, 1024));
            logic [7:0]  l = 8'($urandom_range(0, 15));
            logic [2:0]  s = 3'($urandom_range(0, 3));
            logic [1:0]  bu = 2'($urandom_range(0, 2));
            for (int i = 0; i <= int'(l); i++) begin
                wbuf[i] = {$urandom, $urandom};
                sbuf[i] = 8'($urandom);
            end
            wr_burst(6'($urandom), a, l, s, bu, -1);
            rd_burst(6'($urandom), a, l, s, bu);
        end

        // Reset while beat 2 of a read burst is presented.
        rmode = 0;
        tick();
        ar_issue(6'h0A, 32'h100, 8'd3, 3'd3, 2'b01);
        for (int t = 0; rq.size() > 2; t++) begin
            @(negedge clk);
            if (t > 200) timeout("r_beat2");
        end
        tick();
        check("beat2_data", rdata, 64'h3333_3333_3333_3333);
        reset = 1;
        #1;
        check("rst_mid_rvalid", {63'd0, rvalid}, 64'd0);
        check("rst_mid_rdata", rdata, 64'd0);
        rq.delete();
        repeat (2) tick();
        reset = 0;
        rd_burst(6'h0B, 32'h100, 8'd3, 3'd3, 2'b01);
        check("post_rst_data", last_rdata, 64'h4444_4444_4444_4444);

        summary();
    end

endmodule

// File: doc/jelly_axi4_slave_ram.md
Name: jelly_axi4_slave_ram

Overview:
Parametrised AXI4 slave memory with an internal word array and independent write and read channels. Supports configurable data width, memory depth, read latency and pseudo-random ready throttling.
Used as the DDR stand-in behind the PS memory ports in simulation top-levels, one instance per HP port.
Also usable as a small on-chip scratch RAM in hardware.

Parameters:
ID_WIDTH, 6, width of awid/bid/arid/rid
ADDR_WIDTH, 32, byte address width
DATA_SIZE, 3, log2(bytes per beat); DATA_WIDTH = 8<<DATA_SIZE
MEM_WIDTH, 16, log2(number of words); word index = (addr>>DATA_SIZE) mod 2^MEM_WIDTH
READ_LATENCY, 4, cycles from AR handshake to first rvalid (legal range 1..255)
STALL_ENABLE, 0, 1 = gate awready/wready/arready with LFSR bits
LFSR_SEED, 16'hACE1, LFSR reset value (non-zero)

Ports:
clk  input  1  single clock
reset  input  1  asynchronous, active-high reset
s_axi4_awid/awaddr/awlen[7:0]/awsize[2:0]/awburst[1:0]/awvalid  input  per params  write address
s_axi4_awready  output  1
s_axi4_wdata  input  DATA_WIDTH
s_axi4_wstrb  input  DATA_WIDTH/8
s_axi4_wlast/wvalid  input  1
s_axi4_wready  output  1
s_axi4_bid  output  ID_WIDTH
s_axi4_bresp  output  2
s_axi4_bvalid  output  1
s_axi4_bready  input  1
s_axi4_arid/araddr/arlen[7:0]/arsize[2:0]/arburst[1:0]/arvalid  input  per params  read address
s_axi4_arready  output  1
s_axi4_rid  output  ID_WIDTH
s_axi4_rdata  output  DATA_WIDTH
s_axi4_rresp  output  2
s_axi4_rlast/rvalid  output  1
s_axi4_rready  input  1

Behaviour:
- Reset (asynchronous, mid-burst included):
  - Both FSMs go to IDLE; all ready/valid outputs 0; bid/rid/rdata/bresp/rresp 0; LFSR = LFSR_SEED.
  - Memory contents are NOT cleared.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; advances every cycle.
  - gate = STALL_ENABLE ? lfsr[0] : 1.
  - Readies are gated; valids are never gated or withdrawn once asserted.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready = gate. On AW handshake, capture id, addr, len, size, burst, beat=0, err=0.
  - W_DATA: wready = gate.
    - Each W handshake writes bytes with wstrb set into word(addr).
    - Address step: INCR and WRAP add 1<<size; FIXED holds.
    - Terminates on the beat where beat==len. If wlast != (beat==len) on any beat, set err.
  - W_RESP: bvalid=1, bid=captured id, bresp = err ? 2'b10 : 2'b00; held until bready.
  - Earliest next awready is the cycle after the B handshake.
- Read FSM R_IDLE -> R_WAIT -> R_DATA:
  - R_IDLE: arready = gate. On AR handshake, capture fields and load latency counter = READ_LATENCY-1.
  - R_WAIT: counter decrements. At 0, register rdata = word(addr), rlast = (len==0); next cycle enter R_DATA with rvalid=1.
    - READ_LATENCY=1 gives rvalid in the cycle after the AR handshake.
  - R_DATA: rid/rdata/rlast/rresp stable while rvalid & !rready.
    - On handshake without rlast: advance address as for writes and register the next word.
    - Beats are back-to-back when rready is held high.
    - On handshake with rlast: return to R_IDLE; arready earliest the next cycle.
  - rresp is always 2'b00.
- Write and read channels run concurrently.
  - Same-cycle write and read-load of the same word: read returns the old data.
- Narrow sizes (size < DATA_SIZE) write only strobed lanes; address increments by the narrow size.
- Word index wraps modulo 2^MEM_WIDTH (aliasing).

Decomposition:
- Package jelly_axi4_pkg holds:
  - BURST_FIXED/INCR/WRAP encodings
  - RESP_OKAY/SLVERR
  - write FSM state enum
  - read FSM state enum
- Sub-module jelly_lfsr16_throttle (clk, reset, seed param, enable param -> gate); instantiated once.

Test Plan:
- STALL_ENABLE=0: AW addr 0x100, len 3, INCR, wdata 0x11..,0x22..,0x33..,0x44.., strb all 1 -> one B with bresp 0, bid = awid. Then AR 0x100 len 3 -> those four words in order, rlast on beat 3 only, first rvalid 4 cycles after AR.
- Byte-strobe write of 0xAB to addr 0x203 (strb 8'h08) over word 0xFFFF..FF -> readback 0xFFFF_FFFF_ABFF_FFFF.
- FIXED burst len 2 at 0x40 with data 1,2,3 -> readback of 0x40 = 3.
- wlast asserted on beat 1 of a len 3 burst -> bresp 2'b10 after beat 3; memory still written for all 4 beats.
- STALL_ENABLE=1, rready toggling every cycle, 16 random bursts -> scoreboard match; no valid drops before its handshake; rdata stable while stalled.
- Reset asserted during R_DATA beat 2 -> rvalid 0 immediately; after release, a fresh AR returns the previously written data.
